// File: rtl/atm_pkg.sv
// Shared ATM datapath package: PIN sequencer state encoding and keypad constants.
// The transaction controller decodes pin_state_t, so its encodings are fixed here.
package atm_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
   localparam int CNT_W = 4;
   localparam int FAIL_W = 3;

   typedef enum logic [2:0] {
      PIN_IDLE    = 3'd0,
      PIN_ENTRY   = 3'd1,
      PIN_CHECK   = 3'd2,
      PIN_GRANTED = 3'd3,
      PIN_LOCKED  = 3'd4
   } pin_state_t;

   function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
      return key <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/pin_entry_ctrl_if.sv
// Keypad-side and status signals of the PIN-entry sequencer.
// master = keypad decoder / transaction controller side, slave = pin_entry_ctrl.
interface pin_entry_ctrl_if
   import atm_pkg::*;
#(
   parameter int DIGITS = 4
) ();

   logic                        card_in;
   logic                        cancel;
   logic                        digit_valid;
   logic [DIGIT_W-1:0]          digit;
   logic [DIGIT_W*DIGITS-1:0]   stored_pin;

   logic                        busy;
   logic [CNT_W-1:0]            digit_cnt;
   logic [FAIL_W-1:0]           fail_cnt;
   logic                        auth_ok;
   logic                        bad_pin;
   logic                        lockout;
   logic                        timeout;

   modport master (
      output card_in, cancel, digit_valid, digit, stored_pin,
      input  busy, digit_cnt, fail_cnt, auth_ok, bad_pin, lockout, timeout
   );

   modport slave (
      input  card_in, cancel, digit_valid, digit, stored_pin,
      output busy, digit_cnt, fail_cnt, auth_ok, bad_pin, lockout, timeout
   );

endinterface

// File: rtl/pin_en_reg.sv
// Enable-gated register with asynchronous active-high reset.
module pin_en_reg #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pin_shift_reg.sv
// DIGITS x 4-bit entry shift register; newest digit lands in the low nibble.
// Synchronous clear overrides shift so a retry always starts from an all-zero entry.
module pin_shift_reg
   import atm_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      shift_en,
   input  logic                      clear,
   input  logic [DIGIT_W-1:0]        digit_in,
   output logic [DIGIT_W*DIGITS-1:0] pin_out
);

   logic [DIGIT_W*DIGITS-1:0] next_pin;
   logic                      load;

   assign load     = shift_en | clear;
   assign next_pin = clear ? '0 : {pin_out[DIGIT_W*(DIGITS-1)-1:0], digit_in};

   for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
      pin_en_reg #(
         .W (DIGIT_W)
      ) u_nibble (
         .clk (clk),
         .rst (rst),
         .en  (load),
         .d   (next_pin[DIGIT_W*i +: DIGIT_W]),
         .q   (pin_out[DIGIT_W*i +: DIGIT_W])
      );
   end

endmodule

// File: rtl/pin_entry_ctrl.sv
// PIN-entry sequencer: collects keypad digits, compares against the card PIN, locks after MAX_TRIES.
// Optional inactivity abort in ENTRY is enabled by defining PIN_TIMEOUT_EN.
module pin_entry_ctrl
   import atm_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int MAX_TRIES = 3
`ifdef PIN_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1000
`endif
) (
   input  logic             clk,
   input  logic             rst,
   pin_entry_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIGITS);
   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

   pin_state_t                state_q, state_d;
   logic [DIGIT_W*DIGITS-1:0] entry;
   logic [CNT_W-1:0]          digit_cnt_q, digit_cnt_d;
   logic [FAIL_W-1:0]         fail_cnt_q, fail_cnt_d, fail_next;
   logic                      shift_en, clear_entry;
   logic                      abort, key_ok, timeout_hit;
   logic                      bad_pin_d, timeout_d;
   logic                      busy_q, auth_ok_q, bad_pin_q, lockout_q, timeout_q;

   assign abort     = !bus.card_in || bus.cancel;
   assign key_ok    = bus.digit_valid && is_digit(bus.digit);
   assign fail_next = (fail_cnt_q >= FAIL_MAX) ? FAIL_MAX : fail_cnt_q + FAIL_W'(1);

   pin_shift_reg #(
      .DIGITS (DIGITS)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .clear    (clear_entry),
      .digit_in (bus.digit),
      .pin_out  (entry)
   );

`ifdef PIN_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   logic [IDLE_W-1:0] idle_cnt;

   // Counts ENTRY cycles without an accepted digit; any other state holds it at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (state_q != PIN_ENTRY || shift_en) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end

   assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      digit_cnt_d = digit_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      shift_en    = 1'b0;
      clear_entry = 1'b0;
      bad_pin_d   = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         PIN_IDLE: begin
            clear_entry = 1'b1;
            if (bus.card_in) begin
               state_d = PIN_ENTRY;
            end
         end

         PIN_ENTRY: begin
            if (abort) begin
               state_d = PIN_IDLE;
            end else if (key_ok) begin
               shift_en    = 1'b1;
               digit_cnt_d = digit_cnt_q + CNT_W'(1);
               if (digit_cnt_d == LAST_CNT) begin
                  state_d = PIN_CHECK;
               end
            end else if (timeout_hit) begin
               state_d   = PIN_IDLE;
               timeout_d = 1'b1;
            end
         end

         PIN_CHECK: begin
            if (abort) begin
               state_d = PIN_IDLE;
            end else if (entry == bus.stored_pin) begin
               state_d = PIN_GRANTED;
            end else begin
               fail_cnt_d = fail_next;
               if (fail_next == FAIL_MAX) begin
                  state_d = PIN_LOCKED;
               end else begin
                  state_d     = PIN_ENTRY;
                  digit_cnt_d = '0;
                  clear_entry = 1'b1;
                  bad_pin_d   = 1'b1;
               end
            end
         end

         PIN_GRANTED: begin
            if (abort) begin
               state_d = PIN_IDLE;
            end
         end

         PIN_LOCKED: begin
            state_d = PIN_LOCKED;
         end

         default: begin
            state_d = PIN_IDLE;
         end
      endcase

      // Every path into IDLE (abort, timeout) starts the next card session from scratch.
      if (state_d == PIN_IDLE) begin
         digit_cnt_d = '0;
         fail_cnt_d  = '0;
      end
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PIN_IDLE;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         busy_q      <= 1'b0;
         auth_ok_q   <= 1'b0;
         bad_pin_q   <= 1'b0;
         lockout_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         digit_cnt_q <= digit_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         busy_q      <= (state_d != PIN_IDLE);
         auth_ok_q   <= (state_d == PIN_GRANTED);
         bad_pin_q   <= bad_pin_d;
         lockout_q   <= (state_d == PIN_LOCKED);
         timeout_q   <= timeout_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.digit_cnt = digit_cnt_q;
   assign bus.fail_cnt  = fail_cnt_q;
   assign bus.auth_ok   = auth_ok_q;
   assign bus.bad_pin   = bad_pin_q;
   assign bus.lockout   = lockout_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: directed scenarios plus randomized traffic against a session-level model.
// Covers both builds; the timeout scenario adapts to PIN_TIMEOUT_EN.
module tb_pin_entry_ctrl;

   localparam int DIGITS      = 4;
   localparam int MAX_TRIES   = 3;
   localparam int TIMEOUT_CYC = 20;
`ifdef PIN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   pin_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

   pin_entry_ctrl #(
      .DIGITS      (DIGITS),
      .MAX_TRIES   (MAX_TRIES)
`ifdef PIN_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Session-level reference model: digits typed so far, attempt count and session flags.
   int m_digits[$];
   bit m_active, m_checking, m_granted, m_locked, m_bad, m_to;
   int m_fails, m_idle;

   function automatic void model_reset();
      m_digits.delete();
      m_active = 0; m_checking = 0; m_granted = 0; m_locked = 0;
      m_bad = 0; m_to = 0; m_fails = 0; m_idle = 0;
   endfunction

   function automatic void model_step();
      logic [31:0] val;
      m_bad = 0;
      m_to  = 0;
      if (m_locked) begin
         m_locked = 1;
      end else if (m_active && (!bus.card_in || bus.cancel)) begin
         m_active = 0; m_checking = 0; m_granted = 0; m_fails = 0;
         m_digits.delete();
      end else if (!m_active) begin
         if (bus.card_in) begin
            m_active = 1; m_idle = 0; m_fails = 0;
            m_digits.delete();
         end
      end else if (m_checking) begin
         m_checking = 0;
         val = 0;
         foreach (m_digits[i]) val = (val << 4) | 32'(m_digits[i]);
         if (val == 32'(bus.stored_pin)) begin
            m_granted = 1;
         end else begin
            m_fails++;
            if (m_fails >= MAX_TRIES) begin
               m_locked = 1;
            end else begin
               m_digits.delete();
               m_bad  = 1;
               m_idle = 0;
            end
         end
      end else if (!m_granted) begin
         if (bus.digit_valid && bus.digit <= 4'd9) begin
            m_digits.push_back(int'(bus.digit));
            m_idle = 0;
            if (m_digits.size() == DIGITS) m_checking = 1;
         end else begin
            m_idle++;
            if (TO_EN && m_idle == TIMEOUT_CYC) begin
               m_active = 0; m_fails = 0; m_to = 1;
               m_digits.delete();
            end
         end
      end
   endfunction

   function automatic logic [11:0] exp_pack();
      return {m_active || m_locked, 4'(m_digits.size()), 3'(m_fails),
              m_granted, m_bad, m_locked, m_to};
   endfunction

   function automatic logic [11:0] dut_pack();
      return {bus.busy, bus.digit_cnt, bus.fail_cnt, bus.auth_ok,
              bus.bad_pin, bus.lockout, bus.timeout};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      bus.digit       = k;
      bus.digit_valid = 1'b1;
      tick();
      bus.digit_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus.card_in     = 1'b0;
      bus.cancel      = 1'b0;
      bus.digit_valid = 1'b0;
      bus.digit       = 4'd0;
      rst = 1'b1;
      model_reset();
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      press(4'd1);
      press(4'd2);
      rst = 1'b1;
      model_reset();
      #2;
      n_cmp++;
      if (dut_pack() !== 12'h000) begin
         n_err++;
         $display("[TB] FAIL reset_async: got %h want %h", dut_pack(), 12'h000);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.card_in = 1'b0;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.digit_cnt !== 4'd0) begin
         n_err++;
         $display("[TB] FAIL reset_idle: got busy=%b cnt=%0d want busy=0 cnt=0", bus.busy, bus.digit_cnt);
      end
   endtask

   task automatic test_correct_pin();
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL correct_busy: got %b want 1", bus.busy);
      end
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      n_cmp++;
      if (bus.digit_cnt !== 4'd4 || bus.auth_ok !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL correct_check_cycle: got cnt=%0d auth=%b want cnt=4 auth=0", bus.digit_cnt, bus.auth_ok);
      end
      tick();
      n_cmp++;
      if (bus.auth_ok !== 1'b1 || bus.fail_cnt !== 3'd0) begin
         n_err++;
         $display("[TB] FAIL correct_auth: got auth=%b fail=%0d want auth=1 fail=0", bus.auth_ok, bus.fail_cnt);
      end
      bus.card_in = 1'b0;
      tick();
      n_cmp++;
      if (bus.auth_ok !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL correct_card_out: got auth=%b busy=%b want 0 0", bus.auth_ok, bus.busy);
      end
   endtask

   task automatic test_non_digit();
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      press(4'd1); press(4'd2); press(4'hB);
      n_cmp++;
      if (bus.digit_cnt !== 4'd2) begin
         n_err++;
         $display("[TB] FAIL nondigit_ignored: got cnt=%0d want 2", bus.digit_cnt);
      end
      press(4'd3);
      n_cmp++;
      if (bus.digit_cnt !== 4'd3) begin
         n_err++;
         $display("[TB] FAIL nondigit_cnt3: got cnt=%0d want 3", bus.digit_cnt);
      end
      press(4'd4);
      tick();
      n_cmp++;
      if (bus.auth_ok !== 1'b1 || dut_pack() !== exp_pack()) begin
         n_err++;
         $display("[TB] FAIL nondigit_auth: got %h want %h", dut_pack(), exp_pack());
      end
   endtask

   task automatic test_lockout();
      int bad_seen = 0;
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      for (int a = 0; a < MAX_TRIES; a++) begin
         for (int d = 0; d < DIGITS; d++) press(4'd9);
         tick();
         if (bus.bad_pin === 1'b1) bad_seen++;
         n_cmp++;
         if (bus.fail_cnt !== 3'(a + 1) || bus.lockout !== (a == MAX_TRIES - 1)) begin
            n_err++;
            $display("[TB] FAIL lockout_attempt%0d: got fail=%0d lock=%b want fail=%0d lock=%b",
                     a, bus.fail_cnt, bus.lockout, a + 1, (a == MAX_TRIES - 1));
         end
      end
      n_cmp++;
      if (bad_seen != MAX_TRIES - 1) begin
         n_err++;
         $display("[TB] FAIL lockout_badpin_count: got %0d want %0d", bad_seen, MAX_TRIES - 1);
      end
      bus.card_in = 1'b0;
      bus.cancel  = 1'b1;
      tick(); tick(); tick();
      bus.cancel = 1'b0;
      n_cmp++;
      if (bus.lockout !== 1'b1 || bus.busy !== 1'b1 || dut_pack() !== exp_pack()) begin
         n_err++;
         $display("[TB] FAIL lockout_hold: got %h want %h", dut_pack(), exp_pack());
      end
      do_reset();
      n_cmp++;
      if (bus.lockout !== 1'b0 || bus.fail_cnt !== 3'd0) begin
         n_err++;
         $display("[TB] FAIL lockout_rst: got lock=%b fail=%0d want 0 0", bus.lockout, bus.fail_cnt);
      end
   endtask

   task automatic test_cancel_last();
      int auth_seen = 0;
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      press(4'd1); press(4'd2); press(4'd3);
      bus.cancel = 1'b1;
      press(4'd4);
      bus.cancel = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.digit_cnt !== 4'd0) begin
         n_err++;
         $display("[TB] FAIL cancel_last_idle: got busy=%b cnt=%0d want 0 0", bus.busy, bus.digit_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.auth_ok === 1'b1 || bus.bad_pin === 1'b1) auth_seen++;
      end
      n_cmp++;
      if (auth_seen != 0) begin
         n_err++;
         $display("[TB] FAIL cancel_last_nocheck: got %0d result pulses want 0", auth_seen);
      end
   endtask

   task automatic test_card_pull();
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      press(4'd1); press(4'd2);
      bus.card_in = 1'b0;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.digit_cnt !== 4'd0) begin
         n_err++;
         $display("[TB] FAIL pull_idle: got busy=%b cnt=%0d want 0 0", bus.busy, bus.digit_cnt);
      end
      bus.card_in = 1'b1;
      tick();
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      tick();
      n_cmp++;
      if (bus.auth_ok !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL pull_reinsert_auth: got %b want 1", bus.auth_ok);
      end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int fired_at = -1;
      logic busy_at_fire = 1'b1;
      do_reset();
      bus.stored_pin = 16'h1234;
      bus.card_in = 1'b1;
      tick();
      press(4'd5);
      for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
         tick();
         if (bus.timeout === 1'b1) begin
            pulses++;
            if (fired_at < 0) begin
               fired_at = i;
               busy_at_fire = bus.busy;
               bus.card_in = 1'b0;
            end
         end
      end
      n_cmp++;
      if (TO_EN) begin
         if (pulses != 1 || fired_at != TIMEOUT_CYC - 1 || busy_at_fire !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL timeout_pulse: got pulses=%0d at=%0d busy=%b want 1 at %0d busy=0",
                     pulses, fired_at, busy_at_fire, TIMEOUT_CYC - 1);
         end
      end else begin
         if (pulses != 0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL timeout_absent: got pulses=%0d busy=%b want 0 1", pulses, bus.busy);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] pin;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (!bus.busy && $urandom_range(0, 3) == 0) begin
            for (int d = 0; d < DIGITS; d++) pin[4*d +: 4] = 4'($urandom_range(0, 9));
            bus.stored_pin = pin;
         end
         if (m_locked && $urandom_range(0, 15) == 0) do_reset();
         bus.card_in     = ($urandom_range(0, 39) != 0);
         bus.cancel      = ($urandom_range(0, 59) == 0);
         bus.digit_valid = ($urandom_range(0, 2) != 0);
         if (m_digits.size() < DIGITS && $urandom_range(0, 5) != 0)
            bus.digit = bus.stored_pin[4*(DIGITS - 1 - m_digits.size()) +: 4];
         else
            bus.digit = 4'($urandom_range(0, 15));
         tick();
         n_cmp++;
         if (dut_pack() !== exp_pack()) begin
            n_err++;
            $display("[TB] FAIL random_cycle%0d: got %h want %h", n, dut_pack(), exp_pack());
         end
      end
      bus.digit_valid = 1'b0;
      bus.cancel      = 1'b0;
   endtask

   initial begin
      bus.stored_pin = 16'h0000;
      test_reset();
      test_correct_pin();
      test_non_digit();
      test_lockout();
      test_cancel_last();
      test_card_pull();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pin_entry_ctrl.md
# pin_entry_ctrl

PIN-entry sequencer for the ATM datapath. Collects decimal keypad digits into an enable-gated register bank and compares the completed entry against the card's stored PIN. Tracks failed attempts and locks the session after a fixed number of failures. Sits between the keypad decoder and the transaction controller, which waits on `auth_ok` before allowing any account operation.

## Interface
- `DIGITS`, 4, PIN length in decimal digits (2..8)
- `MAX_TRIES`, 3, failed comparisons before lockout (1..7)
- `TIMEOUT_CYC`, 1000, idle cycles in ENTRY before abort (used only with the timeout feature)

- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `card_in` in 1: card present (level)
- `cancel` in 1: cancel key (single-cycle pulse)
- `digit_valid` in 1: `digit` is valid this cycle
- `digit` in 4: BCD key code
- `stored_pin` in 4*DIGITS: reference PIN, most significant digit in the upper nibble
- `busy` out 1: state is not IDLE
- `digit_cnt` out 4: digits accepted in the current attempt
- `fail_cnt` out 3: failed attempts in the current card session
- `auth_ok` out 1: PIN accepted (level)
- `bad_pin` out 1: one-cycle pulse on a mismatch that does not lock
- `lockout` out 1: session locked (level)
- `timeout` out 1: one-cycle pulse on an inactivity abort

## Operation
- States: IDLE, ENTRY, CHECK, GRANTED, LOCKED.
- **IDLE**
  - `card_in`=1 → ENTRY.
  - Entry register, `digit_cnt` and `fail_cnt` are cleared.
- **ENTRY**
  - `digit_valid`=1 with `digit` ≤ 9: shift in, `entry <= {entry[4*DIGITS-5:0], digit}`, and increment `digit_cnt`.
  - `digit` > 9: ignored; no count and no timer reset.
  - The digit that makes `digit_cnt`==DIGITS → CHECK.
- **CHECK** (exactly one cycle; `digit_valid` ignored)
  - `entry`==`stored_pin` → GRANTED.
  - Otherwise increment `fail_cnt`:
    - new `fail_cnt`==MAX_TRIES → LOCKED.
    - else → ENTRY with `digit_cnt` and `entry` cleared, and `bad_pin` pulsed.
- **GRANTED**
  - `auth_ok`=1 is held.
  - `card_in`=0 or `cancel` → IDLE.
- **LOCKED**
  - `lockout`=1 is held, regardless of `card_in` and `cancel`.
  - Only `rst` exits this state.
- **Abort:** `card_in`=0 or `cancel` in ENTRY or CHECK → IDLE.
- **Priority:** rst > lockout hold > card removal/cancel > CHECK result > digit accept > timeout.
- **Simultaneous last digit and cancel:** cancel wins and no CHECK occurs.
- **`fail_cnt`:** saturates at MAX_TRIES and is cleared only on entry to IDLE or by rst.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `busy` 0, `digit_cnt` 0, `fail_cnt` 0, `auth_ok` 0, `bad_pin` 0, `lockout` 0, `timeout` 0, entry register 0.
- `card_in` rises at cycle N → `busy`=1 at N+1.
- Last digit sampled at cycle N → state CHECK at N+1 → `auth_ok`, `bad_pin` or `lockout` valid at N+2.
- After a `bad_pin` pulse, digits are accepted from N+2 onward.
- `auth_ok` falls in the cycle after `card_in`=0 is sampled.
- Reset mid-operation clears everything immediately, with no completion of an in-flight compare.

## Configuration
- Macro: `PIN_TIMEOUT_EN`.
- **Defined:**
  - An inactivity counter runs in ENTRY only.
  - The counter clears on ENTRY entry and on each accepted digit.
  - After TIMEOUT_CYC consecutive cycles with no accepted digit → IDLE, `timeout` pulses for one cycle, and `fail_cnt` is cleared.
- **Undefined:**
  - No counter logic is present.
  - `timeout` is tied to 0.
  - ENTRY waits indefinitely.

## Structure
- Shared package `atm_pkg`:
  - state enum `pin_state_t`
  - `DIGIT_W`=4
  - `MAX_DIGIT`=9
  - state encodings, so the transaction controller can decode `busy`-adjacent status
- Sub-module `pin_shift_reg`:
  - DIGITS×4-bit shift register built from the team's enable-gated async-reset register.
  - Ports: shift enable, synchronous clear, digit in, parallel out.
- The FSM, counters and compare stay in `pin_entry_ctrl`.

## Test plan
- **Correct PIN:** `stored_pin`=0x1234, card inserted, keys 1,2,3,4 → `auth_ok`=1 exactly two cycles after key 4, `fail_cnt`=0.
- **Non-digit key ignored:** keys 1,2,0xB,3,4 → key 0xB is ignored, `digit_cnt` reaches 4 only after key 4, `auth_ok`=1.
- **Lockout:** three wrong entries of 9,9,9,9 with MAX_TRIES=3 → `bad_pin` pulses twice, `lockout`=1 after the third attempt and stays high through card removal until `rst`.
- **Cancel beats last digit:** `cancel` in the same cycle as key 4 → state IDLE, no `auth_ok`, no `bad_pin`, `digit_cnt`=0.
- **Card pull mid-entry:** `card_in` falls after two digits → IDLE next cycle; reinserting and entering 1,2,3,4 → `auth_ok`.
- **Timeout:** with `PIN_TIMEOUT_EN` and TIMEOUT_CYC=20, one digit followed by 20 idle cycles → `timeout` pulses once, `busy`=0. Without the macro, `timeout` stays 0 throughout.
